// File: rtl/demux_pkg.sv
// ============================================================================
// demux_pkg : shared constants and lane state type for demux1_3_stream
// Revision  : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int NUM_LANES = 3;
  localparam int SEL_W     = 2;
  localparam logic [SEL_W-1:0] SEL_INVALID = 2'd3;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

  function automatic logic lane_hit(input logic [SEL_W-1:0] sel, input int lane);
    return sel == SEL_W'(lane);
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_lane_slot.sv
// ============================================================================
// demux_lane_slot : one-entry output register of a demux lane (load/drain)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module demux_lane_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  lane_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A load wins over a drain so a full lane can refill on the drain edge.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = load_data;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    out_valid = (state_q == FULL);
    out_data  = data_q;
  end

endmodule

`default_nettype wire

// File: rtl/demux1_3_stream.sv
// ============================================================================
// demux1_3_stream : registered 1-to-3 valid/ready stream demultiplexer
// Option          : DEMUX_DROP_CNT_EN enables the saturating drop counter
// Revision        : 1.0
// ============================================================================
`default_nettype none

module demux1_3_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data0,
  output logic [WIDTH-1:0]     out_data1,
  output logic [WIDTH-1:0]     out_data2,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic                 sel_err,
  output logic [CNT_W-1:0]     drop_cnt
);

  logic                 accept;
  logic                 drop;
  logic [NUM_LANES-1:0] lane_load;
  logic [WIDTH-1:0]     lane_data [NUM_LANES];
  logic                 sel_err_q, sel_err_d;

  // Invalid selects are always taken so a bad word never blocks the source.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      2'd0:    in_ready = !out_valid[0] || out_ready[0];
      2'd1:    in_ready = !out_valid[1] || out_ready[1];
      2'd2:    in_ready = !out_valid[2] || out_ready[2];
      default: in_ready = 1'b1;
    endcase
  end

  always_comb begin
    accept = in_valid && in_ready;
    drop   = accept && (in_sel == SEL_INVALID);
  end

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lane_load[i] = accept && lane_hit(in_sel, i);

      demux_lane_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (lane_load[i]),
        .load_data (in_data),
        .out_ready (out_ready[i]),
        .out_valid (out_valid[i]),
        .out_data  (lane_data[i])
      );
    end
  endgenerate

  assign out_data0 = lane_data[0];
  assign out_data1 = lane_data[1];
  assign out_data2 = lane_data[2];

  always_comb begin
    sel_err_d = drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

`ifdef DEMUX_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux1_3_stream.sv
// ============================================================================
// tb_demux1_3_stream : scoreboard bench for demux1_3_stream
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_demux1_3_stream;

  localparam int TB_W     = 8;
  localparam int TB_CNT_W = 3;

  logic                clk;
  logic                rst_n;
  logic [TB_W-1:0]     in_data;
  logic [1:0]          in_sel;
  logic                in_valid;
  logic                in_ready;
  logic [TB_W-1:0]     out_data0, out_data1, out_data2;
  logic [2:0]          out_valid;
  logic [2:0]          out_ready;
  logic                sel_err;
  logic [TB_CNT_W-1:0] drop_cnt;

  demux1_3_stream #(
    .WIDTH (TB_W),
    .CNT_W (TB_CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .drop_cnt  (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: each lane is a FIFO of words the sink has not yet taken.
  logic [TB_W-1:0] exp_q [3][$];
  logic            exp_sel_err;
  int              exp_drop;
  logic            acc_pend;
  logic [1:0]      acc_sel;
  logic [TB_W-1:0] acc_data;

  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [TB_W-1:0] lane_out(input int i);
    case (i)
      0:       return out_data0;
      1:       return out_data1;
      default: return out_data2;
    endcase
  endfunction

  // One bus cycle: commit the previous handshake to the model, drive, check in_ready.
  task automatic cyc(input logic v, input logic [1:0] s, input logic [TB_W-1:0] d,
                     input logic [2:0] r);
    logic exp_rdy;
    @(posedge clk);
    #1;
    exp_sel_err = 1'b0;
    if (acc_pend && rst_n) begin
      if (acc_sel == 2'd3) begin
        exp_sel_err = 1'b1;
`ifdef DEMUX_DROP_CNT_EN
        if (exp_drop < (1 << TB_CNT_W) - 1) exp_drop++;
`endif
      end else begin
        exp_q[acc_sel].push_back(acc_data);
      end
    end
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #2;
    if (s == 2'd3) exp_rdy = 1'b1;
    else           exp_rdy = (exp_q[s].size() == 0) || r[s];
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc_pend = v && exp_rdy && rst_n;
    acc_sel  = s;
    acc_data = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) exp_q[i].delete();
    acc_pend    = 1'b0;
    exp_sel_err = 1'b0;
    exp_drop    = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", {29'd0, out_valid}, 32'd0);
    chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
    chk("rst_drop_cnt", {29'd0, drop_cnt}, 32'd0);
    chk("rst_out_data", {8'd0, out_data2, out_data1, out_data0}, 32'd0);
    model_clear();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic monitor();
    logic [2:0] ev;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) ev[i] = (exp_q[i].size() != 0);
      chk("out_valid", {29'd0, out_valid}, {29'd0, ev});
      for (int i = 0; i < 3; i++) begin
        if (ev[i]) chk($sformatf("out_data%0d", i), {24'd0, lane_out(i)}, {24'd0, exp_q[i][0]});
      end
      chk("sel_err", {31'd0, sel_err}, {31'd0, exp_sel_err});
      chk("drop_cnt", {29'd0, drop_cnt}, exp_drop);
      for (int i = 0; i < 3; i++) begin
        if (rst_n && ev[i] && out_ready[i]) void'(exp_q[i].pop_front());
      end
    end
  endtask

  initial begin
    logic            pv;
    logic [1:0]      ps;
    logic [TB_W-1:0] pd;
    logic [2:0]      pr;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 8'h77;
    out_ready = 3'b000;
    model_clear();

    fork
      monitor();
    join_none

    // Words presented during reset must not be captured.
    repeat (3) cyc(1'b1, 2'd1, 8'h77, 3'b000);
    chk("rst_out_data_hold", {8'd0, out_data2, out_data1, out_data0}, 32'd0);
    model_clear();
    release_reset();
    cyc(1'b1, 2'd1, 8'h5A, 3'b000);
    cyc(1'b0, 2'd0, 8'h00, 3'b000);

    // Back-to-back words to all lanes at full throughput.
    cyc(1'b1, 2'd0, 8'h11, 3'b111);
    cyc(1'b1, 2'd1, 8'h22, 3'b111);
    cyc(1'b1, 2'd2, 8'h33, 3'b111);
    repeat (2) cyc(1'b0, 2'd0, 8'h00, 3'b111);

    // Lane 2 stall, then simultaneous drain and reload.
    cyc(1'b1, 2'd2, 8'hA0, 3'b000);
    repeat (3) cyc(1'b1, 2'd2, 8'hB0, 3'b000);
    cyc(1'b1, 2'd2, 8'hB0, 3'b100);
    cyc(1'b0, 2'd0, 8'h00, 3'b000);
    cyc(1'b0, 2'd0, 8'h00, 3'b111);

    // Lane 0 stalled while lane 1 streams.
    cyc(1'b1, 2'd0, 8'hC0, 3'b000);
    for (int k = 0; k < 5; k++) cyc(1'b1, 2'd1, 8'hD0 + 8'(k), 3'b010);
    cyc(1'b0, 2'd0, 8'h00, 3'b010);
    cyc(1'b0, 2'd0, 8'h00, 3'b111);

    // Invalid selects: four drops, then enough more to saturate.
    repeat (4) cyc(1'b1, 2'd3, 8'hEE, 3'b111);
    cyc(1'b0, 2'd0, 8'h00, 3'b111);
    repeat (5) cyc(1'b1, 2'd3, 8'hEF, 3'b000);
    repeat (2) cyc(1'b0, 2'd0, 8'h00, 3'b000);

    // Asynchronous reset with lanes 0 and 2 holding words.
    cyc(1'b1, 2'd0, 8'hE0, 3'b000);
    cyc(1'b1, 2'd2, 8'hE2, 3'b000);
    cyc(1'b0, 2'd0, 8'h00, 3'b000);
    do_reset();
    repeat (2) cyc(1'b0, 2'd0, 8'h00, 3'b000);
    release_reset();
    cyc(1'b1, 2'd1, 8'h42, 3'b000);
    cyc(1'b0, 2'd0, 8'h00, 3'b111);

    // Random traffic; a stalled source holds its word.
    pv = 1'b0; ps = 2'd0; pd = '0;
    for (int n = 0; n < 800; n++) begin
      if (!(pv && !acc_pend)) begin
        pv = ($urandom_range(0, 3) != 0);
        ps = 2'($urandom_range(0, 3));
        pd = 8'($urandom);
      end
      pr = 3'($urandom);
      cyc(pv, ps, pd, pr);
    end
    repeat (4) cyc(1'b0, 2'd0, 8'h00, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
